// File: rtl/contador_checker_if.sv
// Interface bundling the contador stimulus copies and the outputs under check.
// master: the side that drives the counter signals; slave: the checker.
interface contador_checker_if;
    logic       clr;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] D;
    logic [3:0] Q;
    logic       rco;
    logic       load;

    modport master (
        output clr, enable, mode, D, Q, rco, load
    );

    modport slave (
        input clr, enable, mode, D, Q, rco, load
    );
endinterface

// File: rtl/contador_checker.sv
// Receive-side checker for the 4-bit contador: cycle-exact model, error and rco counters.
// Ports: clk, reset (async, active-low), bus (slave: clr/enable/mode/D in, Q/rco/load
//   under check), synced, chk_valid, err, err_count (saturating), rco_count (wrapping).
// Macro CHECKER_STICKY_EN: first mismatch halts checking until clr; otherwise self-resync.
module contador_checker #(
    parameter int ERR_W = 8,
    parameter int RCO_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    contador_checker_if.slave  bus,
    output logic               synced,
    output logic               chk_valid,
    output logic               err,
    output logic [ERR_W-1:0]   err_count,
    output logic [RCO_W-1:0]   rco_count
);

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        CHECK  = 2'd1,
        HALT   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] mq;
    logic       mrco;
    logic       mload;

    logic       mismatch;
    logic       use_obs;
    logic [3:0] bq;
    logic       brco;
    logic       bload;
    logic [3:0] nq;
    logic       nrco;
    logic       nload;
    logic       sync_ev;

    // Next model value. The base is the observed triple whenever the model is
    // not trusted: before lock, while halted, or right after a mismatch.
    always_comb begin
        mismatch = {bus.Q, bus.rco, bus.load} != {mq, mrco, mload};
        use_obs  = (state != CHECK) || mismatch;
        bq       = use_obs ? bus.Q    : mq;
        brco     = use_obs ? bus.rco  : mrco;
        bload    = use_obs ? bus.load : mload;
        nq       = bq;
        nrco     = brco;
        nload    = bload;
        if (bus.clr) begin
            nq    = 4'd0;
            nrco  = 1'b0;
            nload = 1'b0;
        end else if (bus.enable) begin
            unique case (bus.mode)
                2'b00: begin
                    nq    = bq + 4'd1;
                    nrco  = (nq == 4'hF);
                    nload = 1'b0;
                end
                2'b01: begin
                    nq    = bq - 4'd1;
                    nrco  = (nq == 4'h0);
                    nload = 1'b0;
                end
                2'b10: begin
                    nq    = bq + 4'd3;
                    nrco  = (nq == 4'hF);
                    nload = 1'b0;
                end
                2'b11: begin
                    nq    = bus.D;
                    nrco  = 1'b0;
                    nload = 1'b1;
                end
                default: begin
                    nq    = bq;
                    nrco  = brco;
                    nload = bload;
                end
            endcase
        end
        sync_ev = bus.clr | (bus.enable & (bus.mode == 2'b11));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= UNSYNC;
            synced    <= 1'b0;
            chk_valid <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
            rco_count <= '0;
            mq        <= 4'd0;
            mrco      <= 1'b0;
            mload     <= 1'b0;
        end else begin
            mq        <= nq;
            mrco      <= nrco;
            mload     <= nload;
            chk_valid <= 1'b0;
            err       <= 1'b0;
            unique case (state)
                UNSYNC: begin
                    if (sync_ev) begin
                        state  <= CHECK;
                        synced <= 1'b1;
                    end
                end
                CHECK: begin
                    chk_valid <= 1'b1;
                    err       <= mismatch;
                    if (mismatch && (err_count != '1))
                        err_count <= err_count + ERR_W'(1);
                    if (!mismatch && bus.rco)
                        rco_count <= rco_count + RCO_W'(1);
`ifdef CHECKER_STICKY_EN
                    if (mismatch) begin
                        state  <= HALT;
                        synced <= 1'b0;
                    end
`endif
                end
                HALT: begin
                    if (bus.clr) begin
                        state  <= CHECK;
                        synced <= 1'b1;
                    end
                end
                default: begin
                    state  <= UNSYNC;
                    synced <= 1'b0;
                end
            endcase
        end
    end

endmodule
